// File: rtl/ram_burst_master_pkg.sv
// Shared types and constants for the RAM burst master and its read-return FIFO.
package ram_burst_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } state_e;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and RAM-port signals of the burst master.
interface ram_burst_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic              done;

    logic              ram_do_read;
    logic [ADDR_W-1:0] ram_read_addr;
    logic [DATA_W-1:0] ram_read_data;
    logic              ram_do_write;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [DATA_W-1:0] ram_write_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  ram_read_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, done,
        output ram_do_read, ram_read_addr, ram_do_write, ram_write_addr, ram_write_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output ram_read_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done,
        input  ram_do_read, ram_read_addr, ram_do_write, ram_write_addr, ram_write_data
    );

endinterface

// File: rtl/ram_burst_master_byte_skid_fifo.sv
// Small FIFO catching RAM read returns so the read stream can stall without losing data.
module byte_skid_fifo
    import ram_burst_master_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output logic [DATA_W-1:0]   head,
    output logic [FifoCntW-1:0] count
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    logic [DATA_W-1:0]   mem_q [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [FifoCntW-1:0] count_q;
    logic                do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + FifoCntW'(push) - FifoCntW'(do_pop);
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst controller for the 256x8 on-chip RAM: streams bytes in for write bursts and
// out for read bursts, hiding the RAM's one-cycle read latency behind a 2-entry FIFO.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    ram_burst_master_if.master bus
);

    localparam int unsigned OccW = FifoCntW + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                inflight_q;
    logic                ram_do_write_q;
    logic [ADDR_W-1:0]   ram_write_addr_q;
    logic [DATA_W-1:0]   ram_write_data_q;
    logic [ADDR_W-1:0]   read_addr_hold_q;

    logic                wr_hs;
    logic                issue;
    logic                pop;
    logic                drained;
    logic [FifoCntW-1:0] fifo_count;
    logic [DATA_W-1:0]   fifo_head;
    logic [OccW-1:0]     occ;

    assign wr_hs   = (state_q == StWrite) && bus.wr_valid;
    assign pop     = bus.rd_ready && (fifo_count != '0);
    assign drained = !inflight_q && !ram_do_write_q;

    // Credit counts the byte leaving the FIFO this cycle as already gone, so a new read
    // can be issued alongside a pop and the stream keeps one byte per cycle.
    assign occ   = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
    assign issue = (state_q == StRead) && (occ < OccW'(FifoDepth));

    byte_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.ram_read_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    count_d = bus.cmd_len;
                    state_d = bus.cmd_write ? StWrite : StRead;
                end
            end
            StWrite, StRead: begin
                if (wr_hs || issue) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - ADDR_W'(1);
                    if (count_q == '0) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.cmd_ready      = (state_q == StIdle);
        bus.wr_ready       = (state_q == StWrite);
        bus.rd_valid       = (fifo_count != '0);
        bus.rd_data        = fifo_head;
        bus.done           = (state_q == StDrain) && drained;
        bus.ram_do_read    = issue;
        bus.ram_read_addr  = issue ? addr_q : read_addr_hold_q;
        bus.ram_do_write   = ram_do_write_q;
        bus.ram_write_addr = ram_write_addr_q;
        bus.ram_write_data = ram_write_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q           <= '0;
            count_q          <= '0;
            inflight_q       <= 1'b0;
            ram_do_write_q   <= 1'b0;
            ram_write_addr_q <= '0;
            ram_write_data_q <= '0;
            read_addr_hold_q <= '0;
        end else begin
            addr_q         <= addr_d;
            count_q        <= count_d;
            inflight_q     <= issue;
            ram_do_write_q <= wr_hs;
            if (wr_hs) begin
                ram_write_addr_q <= addr_q;
                ram_write_data_q <= bus.wr_data;
            end
            if (issue) begin
                read_addr_hold_q <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master: directed bursts against a behavioural 256x8 RAM.
module tb_ram_burst_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ram_burst_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_burst_master #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Behavioural RAM: registered read, write commits on ram_do_write
    logic [7:0] mem [256];
    logic [7:0] ram_q;
    bit         preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else begin
            if (bus.ram_do_write) mem[bus.ram_write_addr] <= bus.ram_write_data;
            if (bus.ram_do_read) ram_q <= mem[bus.ram_read_addr];
        end
    end
    assign bus.ram_read_data = ram_q;

    logic [15:0] exp_wr [$];
    logic [7:0]  exp_ra [$];
    logic [7:0]  exp_rd [$];
    int          rd_hs_cyc [$];
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          pending = 0;
    bit          prev_wr_hs = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    bit          mon_rd_hs;
    logic [15:0] mon_w;
    logic [7:0]  mon_b;
    int          cmd_cyc = 0;
    int          wr_hs_cyc = 0;
    bit          rd_toggle = 1'b0;
    bit          rd_hold = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, 64'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.done,
                         bus.ram_do_read, bus.ram_read_addr, bus.ram_do_write,
                         bus.ram_write_addr, bus.ram_write_data}),
              64'({1'b1, 37'd0}));
    endtask

    // Monitor: pops scoreboards whenever the DUT presents activity
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr_hs = 1'b0;
            prev_stall = 1'b0;
            pending    = 0;
        end else begin
            mon_rd_hs = bus.rd_valid && bus.rd_ready;
            if (bus.ram_do_write || prev_wr_hs) check("wr_timing", 64'(bus.ram_do_write), 64'(prev_wr_hs));
            if (bus.ram_do_write) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 64'(bus.ram_write_addr), 64'hFFFF);
                else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr_data", 64'({bus.ram_write_addr, bus.ram_write_data}), 64'(mon_w));
                end
            end
            prev_wr_hs = bus.wr_valid && bus.wr_ready;
            if (bus.ram_do_read) begin
                check("read_credit", 64'((pending - int'(mon_rd_hs)) < 2), 64'd1);
                if (exp_ra.size() == 0) check("ra_unexpected", 64'(bus.ram_read_addr), 64'hFFFF);
                else begin
                    mon_b = exp_ra.pop_front();
                    check("read_addr", 64'(bus.ram_read_addr), 64'(mon_b));
                end
            end
            pending = pending + int'(bus.ram_do_read) - int'(mon_rd_hs);
            if (prev_stall) check("stall_stable", 64'({bus.rd_valid, bus.rd_data}), 64'({1'b1, prev_data}));
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_data  = bus.rd_data;
            if (mon_rd_hs) begin
                rd_hs_cyc.push_back(cyc);
                if (exp_rd.size() == 0) check("rd_unexpected", 64'(bus.rd_data), 64'hFFFF);
                else begin
                    mon_b = exp_rd.pop_front();
                    check("rd_data", 64'(bus.rd_data), 64'(mon_b));
                end
            end
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rd_toggle) bus.rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else bus.rd_ready = rd_hold;
        end
    end

    task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [7:0] l);
        int t = 0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        @(negedge clk);
        while (!bus.cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("cmd_timeout", 64'd0, 64'd1);
        cmd_cyc = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [7:0] d, input int gap);
        int t = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        @(negedge clk);
        while (!bus.wr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("wr_ready_timeout", 64'd0, 64'd1);
        wr_hs_cyc = cyc;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic wait_done(input int start, input string name);
        int t = 0;
        while ((done_cnt == start || exp_rd.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        check({name, "_done_once"}, 64'(done_cnt - start), 64'd1);
        check({name, "_queues_empty"}, 64'(exp_rd.size() + exp_ra.size() + exp_wr.size()), 64'd0);
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [7:0] q[$], input int gap,
                               input string name);
        int start = done_cnt;
        send_cmd(1'b1, a, 8'(q.size() - 1));
        for (int i = 0; i < q.size(); i++) begin
            exp_wr.push_back({a + 8'(i), q[i]});
            send_wr(q[i], (i == q.size() - 1) ? 0 : gap);
        end
        wait_done(start, name);
        check({name, "_done_latency"}, 64'(last_done_cyc - wr_hs_cyc), 64'd2);
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [7:0] l, input string name);
        int start = done_cnt;
        for (int i = 0; i <= int'(l); i++) exp_ra.push_back(a + 8'(i));
        rd_hs_cyc.delete();
        send_cmd(1'b0, a, l);
        wait_done(start, name);
    endtask

    logic [7:0] wq [$];
    int         dstart;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        preload       = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset("reset_state");
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        preload = 1'b0;

        // 4-byte write then read-back at full rate
        wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        write_burst(8'h10, wq, 0, "t1_wr");
        exp_rd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        read_burst(8'h10, 8'd3, "t1_rd");
        check("t1_rd_count", 64'(rd_hs_cyc.size()), 64'd4);
        if (rd_hs_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t1_rd_cycle", 64'(rd_hs_cyc[i]), 64'(cmd_cyc + 3 + i));
        end

        // Wrap across the top of the address space
        exp_rd = '{pat(8'hFE), pat(8'hFF), pat(8'h00), pat(8'h01)};
        read_burst(8'hFE, 8'd3, "t2_wrap");

        // Backpressure pattern 1,0,0,1
        for (int i = 0; i < 8; i++) exp_rd.push_back(pat(8'h40 + 8'(i)));
        rd_toggle = 1'b1;
        read_burst(8'h40, 8'd7, "t3_toggle");
        rd_toggle = 1'b0;

        // Gapped write stream, then read it back
        wq = '{8'h11, 8'h22, 8'h33};
        write_burst(8'h80, wq, 2, "t4_gap_wr");
        exp_rd = '{8'h11, 8'h22, 8'h33};
        read_burst(8'h80, 8'd2, "t4_readback");

        // Reset in the middle of a stalled read burst
        rd_hold = 1'b0;
        for (int i = 0; i < 8; i++) exp_ra.push_back(8'h20 + 8'(i));
        exp_rd = '{pat(8'h20), pat(8'h21)};
        send_cmd(1'b0, 8'h20, 8'd7);
        repeat (5) @(negedge clk);
        check("t5_buffered", 64'({bus.rd_valid, bus.rd_data}), 64'({1'b1, pat(8'h20)}));
        #2;
        rst_n = 1'b0;
        exp_ra.delete();
        exp_rd.delete();
        dstart = done_cnt;
        #1 check_reset("t5_async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rd_hold = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_after_release", 64'({bus.cmd_ready, bus.rd_valid}), 64'({1'b1, 1'b0}));
        repeat (10) @(posedge clk);
        check("t5_no_done", 64'(done_cnt - dstart), 64'd0);

        // Full-RAM write of data = address, then full read
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(8'(i));
        write_burst(8'h00, wq, 0, "t6_full_wr");
        for (int i = 0; i < 256; i++) exp_rd.push_back(8'(i));
        read_burst(8'h00, 8'hFF, "t6_full_rd");
        check("t6_rd_count", 64'(rd_hs_cyc.size()), 64'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
